// File: rtl/aos_softreg_router_n.sv
// rtl/aos_softreg_router_n.sv - flat N-way SoftReg router with in-order read tracking
//
// Routes host SoftReg requests to NUM_APPS apps selected by an address field,
// tracks outstanding reads in issue order, times out silent apps and
// quarantines them, and returns ERR_DATA for reads that cannot be serviced.
//
// Ports:
//   i_clk               user clock
//   i_rst_n             asynchronous active-low reset
//   i_softreg_req       host request  {valid, is_write, addr[31:0], data[63:0]}
//   o_softreg_resp      host response {valid, data[63:0]}
//   o_app_softreg_req   per-app requests, host request layout, all-zero when idle
//   i_app_softreg_resp  per-app responses, host response layout
//   i_app_enable        software enable mask
//   o_quarantine        apps that timed out; treated as disabled until cleared
//   i_quarantine_clr    pulse clears matching quarantine bits
//   o_drop_cnt          saturating count of host requests lost to a full request FIFO
//   o_spurious_cnt      saturating count of app responses matching no outstanding read
module aos_softreg_router_n #(
    parameter int unsigned NUM_APPS      = 4,
    parameter int unsigned SEL_LSB       = 3,
    parameter int unsigned REQ_LOG_DEPTH = 2,
    parameter int unsigned TAG_LOG_DEPTH = 2,
    parameter int unsigned TIMEOUT       = 1024,
    parameter logic [63:0] ERR_DATA      = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [97:0]                i_softreg_req,
    output logic [64:0]                o_softreg_resp,
    output logic [NUM_APPS-1:0][97:0]  o_app_softreg_req,
    input  logic [NUM_APPS-1:0][64:0]  i_app_softreg_resp,
    input  logic [NUM_APPS-1:0]        i_app_enable,
    output logic [NUM_APPS-1:0]        o_quarantine,
    input  logic [NUM_APPS-1:0]        i_quarantine_clr,
    output logic [15:0]                o_drop_cnt,
    output logic [15:0]                o_spurious_cnt
);
    localparam int unsigned SEL_BITS  = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
    // Every select value gets a slot; slots at or above NUM_APPS stay 0 so they are never live.
    localparam int unsigned NPAD      = 1 << SEL_BITS;
    localparam int unsigned REQ_DEPTH = 1 << REQ_LOG_DEPTH;
    localparam int unsigned TAG_DEPTH = 1 << TAG_LOG_DEPTH;
    localparam int unsigned TMR_BITS  = $clog2(TIMEOUT);
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);
    localparam logic [31:0] LOW_MASK  = (32'd1 << SEL_LSB) - 32'd1;

    // Request FIFO holds {is_write, addr, data}; pointers carry one wrap bit.
    logic [96:0]                r_req_mem [REQ_DEPTH];
    logic [REQ_LOG_DEPTH:0]     r_req_wp;
    logic [REQ_LOG_DEPTH:0]     r_req_rp;
    // Tag FIFO holds {idx, err} for every read popped from the request FIFO.
    logic [SEL_BITS:0]          r_tag_mem [TAG_DEPTH];
    logic [TAG_LOG_DEPTH:0]     r_tag_wp;
    logic [TAG_LOG_DEPTH:0]     r_tag_rp;
    logic [TMR_BITS-1:0]        r_timer;
    logic                       r_resp_vld;
    logic [63:0]                r_resp_data;
    logic [NUM_APPS-1:0][97:0]  r_app_req;
    logic [NUM_APPS-1:0]        r_quarantine;
    logic [15:0]                r_drop_cnt;
    logic [15:0]                r_spur_cnt;

    logic                       w_req_in;
    logic                       w_req_empty;
    logic                       w_req_full;
    logic [96:0]                w_head;
    logic                       w_head_wr;
    logic [31:0]                w_head_addr;
    logic [63:0]                w_head_data;
    logic [SEL_BITS-1:0]        w_idx;
    logic [NPAD-1:0]            w_live_vec;
    logic                       w_live;
    logic [31:0]                w_fwd_addr;
    logic                       w_disp;
    logic                       w_tag_push;
    logic                       w_fwd;
    logic                       w_tag_empty;
    logic                       w_tag_full;
    logic [SEL_BITS:0]          w_tag_head;
    logic [SEL_BITS-1:0]        w_th_idx;
    logic                       w_th_err;
    logic [NPAD-1:0]            w_app_vld;
    logic [63:0]                w_hit_data;
    logic                       w_hit;
    logic                       w_tmo;
    logic                       w_tag_pop;
    logic [NPAD-1:0]            w_spur_vec;
    logic [NUM_APPS-1:0]        w_q_set;

    assign w_req_in    = i_softreg_req[97];
    assign w_req_empty = (r_req_wp == r_req_rp);
    assign w_req_full  = ((r_req_wp - r_req_rp) == (REQ_LOG_DEPTH + 1)'(REQ_DEPTH));

    assign w_head      = r_req_mem[r_req_rp[REQ_LOG_DEPTH-1:0]];
    assign w_head_wr   = w_head[96];
    assign w_head_addr = w_head[95:64];
    assign w_head_data = w_head[63:0];
    assign w_idx       = w_head_addr[SEL_LSB +: SEL_BITS];
    assign w_live_vec  = NPAD'(i_app_enable & ~r_quarantine);
    assign w_live      = w_live_vec[w_idx];
    // Select field removed and the upper address bits closed up; top SEL_BITS become 0.
    assign w_fwd_addr  = ((w_head_addr >> (SEL_LSB + SEL_BITS)) << SEL_LSB) | (w_head_addr & LOW_MASK);

    assign w_tag_empty = (r_tag_wp == r_tag_rp);
    assign w_tag_full  = ((r_tag_wp - r_tag_rp) == (TAG_LOG_DEPTH + 1)'(TAG_DEPTH));

    // Writes never need a tag; reads stall at the head until the tag FIFO has room.
    assign w_disp      = !w_req_empty && (w_head_wr || !w_tag_full);
    assign w_tag_push  = w_disp && !w_head_wr;
    assign w_fwd       = w_disp && w_live;

    assign w_tag_head  = r_tag_mem[r_tag_rp[TAG_LOG_DEPTH-1:0]];
    assign w_th_idx    = w_tag_head[SEL_BITS:1];
    assign w_th_err    = w_tag_head[0];

    always_comb begin
        w_app_vld  = '0;
        w_hit_data = '0;
        w_q_set    = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            w_app_vld[i] = i_app_softreg_resp[i][64];
            if (w_th_idx == SEL_BITS'(i)) begin
                w_hit_data = i_app_softreg_resp[i][63:0];
                w_q_set[i] = w_tmo;
            end
        end
    end

    assign w_hit      = !w_tag_empty && !w_th_err && w_app_vld[w_th_idx];
    // A response arriving on the timeout cycle still wins over the timeout.
    assign w_tmo      = !w_tag_empty && !w_th_err && !w_hit && (r_timer == TMR_LAST);
    assign w_tag_pop  = (!w_tag_empty && w_th_err) || w_hit || w_tmo;
    assign w_spur_vec = w_app_vld & ~(w_hit ? (NPAD'(1) << w_th_idx) : NPAD'(0));

    // FIFO storage carries no reset; occupancy is defined purely by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_req_in && !w_req_full) begin
            r_req_mem[r_req_wp[REQ_LOG_DEPTH-1:0]] <= i_softreg_req[96:0];
        end
        if (w_tag_push) begin
            r_tag_mem[r_tag_wp[TAG_LOG_DEPTH-1:0]] <= {w_idx, !w_live};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_wp     <= '0;
            r_req_rp     <= '0;
            r_tag_wp     <= '0;
            r_tag_rp     <= '0;
            r_timer      <= '0;
            r_resp_vld   <= 1'b0;
            r_resp_data  <= '0;
            r_app_req    <= '0;
            r_quarantine <= '0;
            r_drop_cnt   <= '0;
            r_spur_cnt   <= '0;
        end else begin
            if (w_req_in && !w_req_full) begin
                r_req_wp <= r_req_wp + (REQ_LOG_DEPTH + 1)'(1);
            end
            if (w_req_in && w_req_full && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_disp) begin
                r_req_rp <= r_req_rp + (REQ_LOG_DEPTH + 1)'(1);
            end
            if (w_tag_push) begin
                r_tag_wp <= r_tag_wp + (TAG_LOG_DEPTH + 1)'(1);
            end
            if (w_tag_pop) begin
                r_tag_rp <= r_tag_rp + (TAG_LOG_DEPTH + 1)'(1);
            end
            // Timer measures how long the current err=0 head has been waiting.
            if (w_tag_pop || w_tag_empty || w_th_err) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_BITS'(1);
            end
            r_resp_vld  <= w_tag_pop;
            r_resp_data <= w_hit ? w_hit_data : (w_tag_pop ? ERR_DATA : 64'd0);
            if ((|w_spur_vec) && (r_spur_cnt != 16'hFFFF)) begin
                r_spur_cnt <= r_spur_cnt + 16'd1;
            end
            // Set from a timeout wins over a same-cycle clear.
            r_quarantine <= (r_quarantine & ~i_quarantine_clr) | w_q_set;
            for (int i = 0; i < NUM_APPS; i++) begin
                if (w_fwd && (w_idx == SEL_BITS'(i))) begin
                    r_app_req[i] <= {1'b1, w_head_wr, w_fwd_addr, w_head_data};
                end else begin
                    r_app_req[i] <= '0;
                end
            end
        end
    end

    assign o_softreg_resp    = {r_resp_vld, r_resp_data};
    assign o_app_softreg_req = r_app_req;
    assign o_quarantine      = r_quarantine;
    assign o_drop_cnt        = r_drop_cnt;
    assign o_spurious_cnt    = r_spur_cnt;
endmodule

// File: tb/tb_aos_softreg_router_n.sv
// tb/tb_aos_softreg_router_n.sv - self-checking bench for aos_softreg_router_n
module tb_aos_softreg_router_n;
    localparam int NA = 3;
    localparam int TMO = 16;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [97:0]          req;
    logic [64:0]          resp;
    logic [NA-1:0][97:0]  app_req;
    logic [NA-1:0][64:0]  app_resp;
    logic [NA-1:0]        en, q, qclr;
    logic [15:0]          drop, spur;

    logic [97:0]          req_s;
    logic [64:0]          resp_s;
    logic [0:0][97:0]     app_req_s;
    logic [0:0][64:0]     app_resp_s;
    logic [0:0]           en_s, q_s, qclr_s;
    logic [15:0]          drop_s, spur_s;

    aos_softreg_router_n #(.NUM_APPS(NA), .SEL_LSB(3), .REQ_LOG_DEPTH(2), .TAG_LOG_DEPTH(1),
                           .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_softreg_req(req), .o_softreg_resp(resp),
        .o_app_softreg_req(app_req), .i_app_softreg_resp(app_resp), .i_app_enable(en),
        .o_quarantine(q), .i_quarantine_clr(qclr), .o_drop_cnt(drop), .o_spurious_cnt(spur));

    aos_softreg_router_n #(.NUM_APPS(1), .SEL_LSB(3), .REQ_LOG_DEPTH(2), .TAG_LOG_DEPTH(1),
                           .TIMEOUT(100000), .ERR_DATA(ERR)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_softreg_req(req_s), .o_softreg_resp(resp_s),
        .o_app_softreg_req(app_req_s), .i_app_softreg_resp(app_resp_s), .i_app_enable(en_s),
        .o_quarantine(q_s), .i_quarantine_clr(qclr_s), .o_drop_cnt(drop_s), .o_spurious_cnt(spur_s));

    typedef struct {
        int          cyc;
        int          app;
        logic        w;
        logic [31:0] addr;
        logic [63:0] data;
    } app_ev_t;
    typedef struct {
        int          cyc;
        logic [63:0] data;
    } host_ev_t;

    app_ev_t  app_q[$], exp_app[$], app_s_q[$];
    host_ev_t host_q[$], exp_host[$], host_s_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic is logged mid-cycle; idle ports must carry all-zero fields.
    always @(negedge clk) begin
        for (int i = 0; i < NA; i++) begin
            if (app_req[i][97]) begin
                app_q.push_back('{cyc, i, app_req[i][96], app_req[i][95:64], app_req[i][63:0]});
            end else begin
                n_chk++;
                assert (app_req[i] === 98'd0) else begin
                    n_fail++;
                    $error("FAIL idle_zero app%0d observed=%0h expected=0", i, app_req[i]);
                end
            end
        end
        if (resp[64]) host_q.push_back('{cyc, resp[63:0]});
        if (app_req_s[0][97]) app_s_q.push_back('{cyc, 0, app_req_s[0][96], app_req_s[0][95:64], app_req_s[0][63:0]});
        if (resp_s[64]) host_s_q.push_back('{cyc, resp_s[63:0]});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input logic w, input logic [31:0] a, input logic [63:0] d);
        req = {1'b1, w, a, d};
        tick();
        req = '0;
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_app_count"}, 64'(app_q.size()), 64'(exp_app.size()));
        chk({tag, "_host_count"}, 64'(host_q.size()), 64'(exp_host.size()));
        for (int i = 0; i < exp_app.size() && i < app_q.size(); i++) begin
            chk({tag, "_app_cyc"}, 64'(app_q[i].cyc), 64'(exp_app[i].cyc));
            chk({tag, "_app_idx"}, 64'(app_q[i].app), 64'(exp_app[i].app));
            chk({tag, "_app_wr"}, 64'(app_q[i].w), 64'(exp_app[i].w));
            chk({tag, "_app_addr"}, 64'(app_q[i].addr), 64'(exp_app[i].addr));
            chk({tag, "_app_data"}, app_q[i].data, exp_app[i].data);
        end
        for (int i = 0; i < exp_host.size() && i < host_q.size(); i++) begin
            chk({tag, "_host_cyc"}, 64'(host_q[i].cyc), 64'(exp_host[i].cyc));
            chk({tag, "_host_data"}, host_q[i].data, exp_host[i].data);
        end
        app_q.delete();
        host_q.delete();
        exp_app.delete();
        exp_host.delete();
    endtask

    int          c, a_cyc, rc, k, x, spur_m;
    logic [1:0]  idx, other;
    logic        w, live, extra;
    logic [2:0]  q_m;
    logic [31:0] addr, fwd;
    logic [63:0] data, rdata;

    initial begin
        rst_n = 1'b0;
        req = '0; app_resp = '0; en = '0; qclr = '0;
        req_s = '0; app_resp_s = '0; en_s = '0; qclr_s = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_resp", 64'(resp), 64'd0);
        for (int i = 0; i < NA; i++) chk("rst_app_req", 64'(app_req[i][97:64]), 64'd0);
        chk("rst_quarantine", 64'(q), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_spur", 64'(spur), 64'd0);

        // Write routing: idx 2, forwarded addr with select field removed
        en = 3'b111;
        c = cyc;
        host(1'b1, 32'h10, 64'h55);
        exp_app.push_back('{c + 2, 2, 1'b1, 32'h0, 64'h55});
        repeat (4) tick();
        check_logs("wr_route");

        // In-order reads: idx2 then idx0; app0 answers first -> spurious
        c = cyc;
        host(1'b0, 32'h10, 64'h0);
        host(1'b0, 32'h00, 64'h0);
        exp_app.push_back('{c + 2, 2, 1'b0, 32'h0, 64'h0});
        exp_app.push_back('{c + 3, 0, 1'b0, 32'h0, 64'h0});
        x = c + 5;
        while (cyc < x) tick();
        app_resp[0] = {1'b1, 64'hA1};
        tick();
        app_resp = '0;
        app_resp[2] = {1'b1, 64'hB2};
        tick();
        app_resp = '0;
        exp_host.push_back('{x + 2, 64'hB2});
        exp_host.push_back('{x + 2 + TMO, ERR});
        while (cyc < x + TMO + 4) tick();
        check_logs("in_order");
        chk("in_order_spur", 64'(spur), 64'd1);
        chk("in_order_quar", 64'(q), 64'b001);

        // Timeout, quarantine, clear
        qclr = 3'b111;
        tick();
        qclr = '0;
        c = cyc;
        host(1'b0, 32'h08, 64'h0);
        a_cyc = c + 2;
        exp_app.push_back('{a_cyc, 1, 1'b0, 32'h0, 64'h0});
        exp_host.push_back('{a_cyc + TMO, ERR});
        while (cyc < a_cyc + TMO + 2) tick();
        check_logs("timeout");
        chk("timeout_quar", 64'(q), 64'b010);
        c = cyc;
        host(1'b0, 32'h08, 64'h0);
        exp_host.push_back('{c + 3, ERR});
        repeat (4) tick();
        check_logs("quar_read");
        qclr = 3'b010;
        tick();
        qclr = '0;
        chk("quar_clr", 64'(q), 64'b000);
        c = cyc;
        host(1'b0, 32'h08, 64'h0);
        exp_app.push_back('{c + 2, 1, 1'b0, 32'h0, 64'h0});
        while (cyc < c + 4) tick();
        app_resp[1] = {1'b1, 64'h1234};
        tick();
        app_resp = '0;
        exp_host.push_back('{c + 5, 64'h1234});
        repeat (3) tick();
        check_logs("after_clr");

        // Out-of-range and disabled targets
        c = cyc;
        host(1'b0, 32'h18, 64'h0);
        exp_host.push_back('{c + 3, ERR});
        repeat (4) tick();
        en = 3'b110;
        host(1'b1, 32'h00, 64'h99);
        c = cyc;
        host(1'b0, 32'h00, 64'h0);
        exp_host.push_back('{c + 3, ERR});
        repeat (4) tick();
        check_logs("disabled");
        chk("disabled_spur", 64'(spur), 64'd1);

        // Randomized single transactions against a transaction-level model
        spur_m = 1;
        qclr = 3'b111;
        tick();
        qclr = '0;
        q_m = 3'b000;
        for (int it = 0; it < 40; it++) begin
            en = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                qclr = 3'($urandom);
                tick();
                q_m = q_m & ~qclr;
                qclr = '0;
            end
            idx = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            if (it < 2) begin
                idx = 2'(it);
                w = 1'b0;
                en = 3'b111;
                q_m = q_m & 3'b100;
                qclr = 3'b011;
                tick();
                qclr = '0;
            end
            addr = $urandom;
            addr[4:3] = idx;
            data = {$urandom, $urandom};
            fwd = {2'b00, addr[31:5], addr[2:0]};
            live = (idx < 2'd3) && en[idx] && !q_m[idx];
            c = cyc;
            host(w, addr, data);
            if (w) begin
                if (live) exp_app.push_back('{c + 2, int'(idx), 1'b1, fwd, data});
                repeat (4) tick();
            end else if (!live) begin
                exp_host.push_back('{c + 3, ERR});
                repeat (4) tick();
            end else begin
                a_cyc = c + 2;
                exp_app.push_back('{a_cyc, int'(idx), 1'b0, fwd, data});
                k = (it == 0) ? TMO - 1 : (it == 1) ? TMO : $urandom_range(0, TMO + 3);
                rc = a_cyc + k;
                rdata = {$urandom, $urandom};
                extra = 1'($urandom_range(0, 1));
                other = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                if (k < TMO) begin
                    exp_host.push_back('{rc + 1, rdata});
                end else begin
                    exp_host.push_back('{a_cyc + TMO, ERR});
                    q_m[idx] = 1'b1;
                end
                if (k >= TMO || extra) spur_m++;
                while (cyc < rc) tick();
                app_resp[idx] = {1'b1, rdata};
                if (extra) app_resp[other] = {1'b1, ~rdata};
                tick();
                app_resp = '0;
                repeat (4) tick();
            end
            check_logs("rand");
            chk("rand_spur", 64'(spur), 64'(spur_m));
            chk("rand_quar", 64'(q), 64'(q_m));
        end

        // Backpressure: tag FIFO of 2, request FIFO of 4
        qclr = 3'b111;
        en = 3'b111;
        tick();
        qclr = '0;
        c = cyc;
        host(1'b0, 32'h00, 64'h0);
        host(1'b0, 32'h08, 64'h0);
        host(1'b0, 32'h10, 64'h0);
        for (int i = 0; i < 6; i++) host(1'b1, 32'h10, 64'(i));
        exp_app.push_back('{c + 2, 0, 1'b0, 32'h0, 64'h0});
        exp_app.push_back('{c + 3, 1, 1'b0, 32'h0, 64'h0});
        tick();
        chk("bp_drop", 64'(drop), 64'd3);
        check_logs("bp");

        // Asynchronous reset with two reads outstanding
        #1 rst_n = 1'b0;
        #1;
        chk("arst_resp", 64'(resp), 64'd0);
        for (int i = 0; i < NA; i++) chk("arst_app_req", 64'(app_req[i][97:64]), 64'd0);
        chk("arst_drop", 64'(drop), 64'd0);
        chk("arst_spur", 64'(spur), 64'd0);
        chk("arst_quar", 64'(q), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        app_resp[0] = {1'b1, 64'h11};
        tick();
        app_resp = '0;
        app_resp[1] = {1'b1, 64'h22};
        tick();
        app_resp = '0;
        repeat (20) tick();
        check_logs("arst_late");
        chk("arst_late_spur", 64'(spur), 64'd2);

        // Single-app instance: idx 1 not live, field removal with one select bit
        en_s = 1'b1;
        c = cyc;
        req_s = {1'b1, 1'b0, 32'h08, 64'h0};
        tick();
        req_s = '0;
        repeat (4) tick();
        chk("s_idx1_count", 64'(host_s_q.size()), 64'd1);
        if (host_s_q.size() > 0) begin
            chk("s_idx1_cyc", 64'(host_s_q[0].cyc), 64'(c + 3));
            chk("s_idx1_data", host_s_q[0].data, ERR);
        end
        chk("s_idx1_app", 64'(app_s_q.size()), 64'd0);
        host_s_q.delete();
        c = cyc;
        req_s = {1'b1, 1'b0, 32'h0000_0F05, 64'h0};
        tick();
        req_s = '0;
        tick();
        tick();
        app_resp_s[0] = {1'b1, 64'h77};
        tick();
        app_resp_s = '0;
        repeat (3) tick();
        chk("s_rd_app_count", 64'(app_s_q.size()), 64'd1);
        if (app_s_q.size() > 0) begin
            chk("s_rd_app_cyc", 64'(app_s_q[0].cyc), 64'(c + 2));
            chk("s_rd_app_addr", 64'(app_s_q[0].addr), 64'h785);
        end
        chk("s_rd_host_count", 64'(host_s_q.size()), 64'd1);
        if (host_s_q.size() > 0) begin
            chk("s_rd_host_cyc", 64'(host_s_q[0].cyc), 64'(c + 4));
            chk("s_rd_host_data", host_s_q[0].data, 64'h77);
        end
        app_s_q.delete();
        host_s_q.delete();

        // Drop counter: 6 reads accepted, the rest overflow and saturate
        req_s = {1'b1, 1'b0, 32'h0, 64'h0};
        repeat (1006) tick();
        chk("s_drop_1000", 64'(drop_s), 64'd1000);
        repeat (64600) tick();
        req_s = '0;
        tick();
        chk("s_drop_sat", 64'(drop_s), 64'hFFFF);
        chk("s_sat_app_count", 64'(app_s_q.size()), 64'd2);
        chk("s_sat_host_count", 64'(host_s_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aos_softreg_router_n.md
Name: aos_softreg_router_n

Overview:
Flat N-way SoftReg router with in-order read tracking. It sits between the host SoftReg interface and NUM_APPS virtualized apps, replacing the binary 1-to-2 / 2-to-1 route trees. It adds the following over the route trees:
- configurable select field
- bounded outstanding reads with per-read timeout
- error responses
- per-app enable/quarantine
- drop counters

Parameters:
NUM_APPS, 4, number of app ports (1..16)
SEL_LSB, 3, LSB of app-select field in addr
REQ_LOG_DEPTH, 2, log2 depth of host request FIFO
TAG_LOG_DEPTH, 2, log2 max outstanding reads
TIMEOUT, 1024, cycles a read may wait before an error response is emitted (>=2)
ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, data returned on error
Derived: SEL_BITS = max(1, clog2(NUM_APPS))

Ports:
clk  in  1  user clock
rst_n  in  1  asynchronous active-low reset
softreg_req  in  SoftRegReq(98: valid,isWrite,addr[31:0],data[63:0])  host request
softreg_resp  out  SoftRegResp(65: valid,data[63:0])  response to host
app_softreg_req  out  SoftRegReq[NUM_APPS]  per-app requests
app_softreg_resp  in  SoftRegResp[NUM_APPS]  per-app responses
app_enable  in  NUM_APPS  software enable mask
quarantine  out  NUM_APPS  app timed out; treated as disabled
quarantine_clr  in  NUM_APPS  one-cycle pulse clears matching quarantine bits
drop_cnt  out  16  saturating count of requests lost to full FIFO
spurious_cnt  out  16  saturating count of unexpected app responses

Behaviour:
- Reset (async assert, sync deassert via rst_n): all valids 0, all FIFOs empty, quarantine 0, counters 0, timer 0.
- Outputs are registered. All app port data fields are 0 when valid=0.
- Request intake:
  - softreg_req.valid with request FIFO not full → enqueue.
  - softreg_req.valid with request FIFO full → discard and increment drop_cnt (saturates at FFFF).
- Decode of FIFO head: idx = addr[SEL_LSB +: SEL_BITS]. Target is live iff idx<NUM_APPS && app_enable[idx] && !quarantine[idx].
- Dispatch, at most one head per cycle:
  - Write, live → pop; drive app_softreg_req[idx] valid next cycle.
  - Write, not live → pop; silently drop.
  - Read → requires tag FIFO not full; otherwise head stalls (no pop). When tag FIFO has room:
    - live: pop, push tag {idx, err=0}, drive app next cycle.
    - not live: pop, push {idx, err=1}; no app request is issued.
- Forwarded addr = {SEL_BITS'b0, addr[31:SEL_LSB+SEL_BITS], addr[SEL_LSB-1:0]}. data and isWrite pass unchanged.
- Latency: with both FIFOs empty, a host request at cycle t appears at the app at t+2 (FIFO + output register).
- Response matching, against the tag FIFO head only:
  - Head err=1 → next cycle softreg_resp = {1, ERR_DATA}; pop.
  - app_softreg_resp[head.idx].valid → next cycle softreg_resp = {1, that data}; pop; timer=0.
  - Any other app response valid (other idx, or tag FIFO empty) → discard and increment spurious_cnt once per cycle, even when several arrive in the same cycle.
  - Correct and spurious responses arriving in the same cycle → correct one forwarded, counter +1.
- Timeout:
  - Timer counts cycles while the tag head is err=0 and unanswered.
  - Timer == TIMEOUT-1 with no response that cycle → emit {1, ERR_DATA}, pop, set quarantine[head.idx], timer=0.
  - A later response from that app counts as spurious.
- Reads complete to the host strictly in issue order. At most one softreg_resp valid per cycle.
- Quarantine semantics:
  - Setting quarantine does not flush already-queued tags for that idx; those wait for their own response or timeout.
  - quarantine_clr and a timeout setting the same bit in the same cycle → set wins.
  - Deasserting app_enable mid-read does not cancel outstanding tags.
- Reset mid-operation: all in-flight requests and tags are lost; no responses are emitted afterward.
- NUM_APPS==1: idx field still decoded with SEL_BITS=1; idx 1 is not live.

Test Plan:
- Write routing, NUM_APPS=4: write addr=0x18 (idx 3) data=0x55 → app3 valid 2 cycles later, addr=0x0, data=0x55; other apps quiet; no host resp.
- In-order reads: reads to idx2 then idx0. App0 answers 0xA1 first, app2 answers 0xB2 one cycle later → app0's response counts spurious (spurious_cnt=1). Host gets 0xB2 for the first read; the second read then times out with ERR_DATA and quarantine[0]=1.
- Timeout, TIMEOUT=16: read to idx1, app silent → exactly 16 cycles after dispatch, softreg_resp={1,ERR_DATA}, quarantine=4'b0010. A subsequent read to idx1 → immediate ERR_DATA, no app1 request. quarantine_clr=4'b0010 → the next read reaches app1.
- Disabled/out-of-range, NUM_APPS=3: read addr idx 3 → ERR_DATA, no app valid. Write with app_enable[0]=0 → dropped silently.
- Backpressure, TAG_LOG_DEPTH=1: 3 back-to-back reads, apps silent → 2 dispatched, third stalls. Further host writes fill the req FIFO; excess writes increment drop_cnt by exact overflow count. drop_cnt saturates at 0xFFFF after 70000 overflows.
- Async reset: assert rst_n=0 mid-cycle with 2 reads outstanding → all outputs 0 immediately. After release, late app responses → spurious_cnt=1 each, no host resp.
